// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Shared state encoding, opcode constants, ALU control codes
//                and the opcode class record for the multicycle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

  // Controller states; codes 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  // Major opcodes (instruction[6:0]).
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU control encodings.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b01;
  localparam logic [1:0] ALU_CMP   = 2'b10;

  // One-hot instruction class.
  typedef struct packed {
    logic r;
    logic ialu;
    logic load;
    logic store;
    logic branch;
    logic illegal;
  } op_class_t;

endpackage : control_pkg
`default_nettype wire

// File: rtl/opcode_class.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_class
//  Description : Combinational one-hot classifier of the 7-bit major opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module opcode_class
  import control_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  class_o
);

  // Exactly one class bit is set; anything unrecognised is ILLEGAL.
  always_comb begin
    class_o = '0;
    case (opcode_i)
      OP_R:      class_o.r       = 1'b1;
      OP_IALU:   class_o.ialu    = 1'b1;
      OP_LOAD:   class_o.load    = 1'b1;
      OP_STORE:  class_o.store   = 1'b1;
      OP_BRANCH: class_o.branch  = 1'b1;
      default:   class_o.illegal = 1'b1;
    endcase
  end

endmodule : opcode_class
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multicycle processor control FSM (fetch/decode/exec/mem/wb)
//                with memory handshake and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import control_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  opcode_i,
  input  logic        branch_taken_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic [1:0]  alu_control_o,
  output logic        alu_src_2_o,
  output logic        reg_write_o,
  output logic        wb_sel_o,
  output logic        illegal_o,
  output logic        retired_o,
  output logic [31:0] instret_o,
  output logic [2:0]  state_o
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  op_class_t   op_cls;
  state_e      next_instr;
  logic        retire_evt;

  opcode_class u_opcode_class (
    .opcode_i (opcode_i),
    .class_o  (op_cls)
  );

  // Where a retiring instruction goes: keep running while start_i is held.
  assign next_instr = start_i ? ST_FETCH : ST_IDLE;

  // State and retired-count registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and Mealy output decode; every output defaults to 0.
  always_comb begin
    state_d        = state_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    pc_src_o       = 1'b0;
    alu_control_o  = ALU_ADD;
    alu_src_2_o    = 1'b0;
    reg_write_o    = 1'b0;
    wb_sel_o       = 1'b0;
    illegal_o      = 1'b0;
    retire_evt     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        // Request is held with PC address until memory answers.
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (op_cls.illegal) begin
          illegal_o  = 1'b1;
          retire_evt = 1'b1;
          state_d    = next_instr;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (op_cls.r) begin
          alu_control_o = ALU_FUNCT;
          state_d       = ST_WB;
        end else if (op_cls.ialu) begin
          alu_control_o = ALU_FUNCT;
          alu_src_2_o   = 1'b1;
          state_d       = ST_WB;
        end else if (op_cls.load || op_cls.store) begin
          alu_src_2_o = 1'b1;
          state_d     = ST_MEM;
        end else if (op_cls.branch) begin
          alu_control_o = ALU_CMP;
          pc_write_o    = branch_taken_i;
          pc_src_o      = branch_taken_i;
          retire_evt    = 1'b1;
          state_d       = next_instr;
        end else begin
          // Opcode changed under us; abandon the instruction.
          state_d = ST_IDLE;
        end
      end

      ST_MEM: begin
        // Address still comes from the ALU, so keep its controls steady.
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = op_cls.store;
        alu_src_2_o    = 1'b1;
        if (mem_ready_i) begin
          if (op_cls.store) begin
            retire_evt = 1'b1;
            state_d    = next_instr;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = op_cls.load;
        retire_evt  = 1'b1;
        state_d     = next_instr;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Counter wraps naturally at 32 bits.
  assign instret_d = instret_q + {31'd0, retire_evt};

  assign retired_o = retire_evt;
  assign instret_o = instret_q;
  assign state_o   = state_q;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed self-checking bench for multicycle_control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_BAD    = 7'h7F;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [6:0]  opcode_i;
  logic        branch_taken_i;
  logic        mem_ready_i;
  logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o;
  logic        pc_write_o, pc_src_o, alu_src_2_o;
  logic [1:0]  alu_control_o;
  logic        reg_write_o, wb_sel_o, illegal_o, retired_o;
  logic [31:0] instret_o;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .mem_ready_i    (mem_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_sel_o (mem_addr_sel_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .pc_src_o       (pc_src_o),
    .alu_control_o  (alu_control_o),
    .alu_src_2_o    (alu_src_2_o),
    .reg_write_o    (reg_write_o),
    .wb_sel_o       (wb_sel_o),
    .illegal_o      (illegal_o),
    .retired_o      (retired_o),
    .instret_o      (instret_o),
    .state_o        (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs then change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Settle combinational outputs after changing inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; opcode_i = C_OP_R;
    branch_taken_i = 1'b0; mem_ready_i = 1'b0;
    tick(); tick();
    settle();
    // Reset state: every output quiet.
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_instret", instret_o, 32'd0);
    check("rst_outs", 32'({mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o,
                          pc_src_o, alu_control_o, alu_src_2_o, reg_write_o, wb_sel_o,
                          illegal_o, retired_o}), 32'd0);

    // ---- R-type, zero-wait memory: 1,2,3,5,1 ----
    rst_i = 1'b1; start_i = 1'b1; mem_ready_i = 1'b1; opcode_i = C_OP_R;
    tick(); settle();
    check("r_fetch_state", 32'(state_o), 32'd1);
    check("r_fetch_ctl", 32'({mem_req_o, mem_addr_sel_o, mem_we_o, ir_write_o, pc_write_o, pc_src_o}), 32'b100110);
    tick(); settle();
    check("r_decode_state", 32'(state_o), 32'd2);
    tick(); settle();
    check("r_exec_state", 32'(state_o), 32'd3);
    check("r_exec_alu", 32'({alu_control_o, alu_src_2_o}), 32'b010);
    tick(); settle();
    check("r_wb_state", 32'(state_o), 32'd5);
    check("r_wb_ctl", 32'({reg_write_o, wb_sel_o, retired_o}), 32'b101);
    tick(); settle();
    check("r_next_state", 32'(state_o), 32'd1);
    check("r_instret", instret_o, 32'd1);

    // ---- LOAD with three wait cycles in MEM ----
    opcode_i = C_OP_LOAD;
    tick(); tick(); settle();
    check("ld_exec_alu", 32'({state_o, alu_control_o, alu_src_2_o}), 32'b011_00_1);
    tick();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready_i = 1'b1;
      settle();
      check($sformatf("ld_mem_%0d", i),
            32'({state_o, mem_req_o, mem_addr_sel_o, mem_we_o, alu_control_o, alu_src_2_o}),
            32'b100_110_00_1);
      check($sformatf("ld_mem_ret_%0d", i), 32'(retired_o), 32'd0);
      if (i < 3) tick();
    end
    tick(); start_i = 1'b0; settle();
    check("ld_wb", 32'({state_o, reg_write_o, wb_sel_o, retired_o}), 32'b101_111);
    tick(); settle();
    check("ld_idle", 32'(state_o), 32'd0);
    check("ld_instret", instret_o, 32'd2);

    // ---- BRANCH taken then not taken ----
    start_i = 1'b1; mem_ready_i = 1'b1; opcode_i = C_OP_BRANCH; branch_taken_i = 1'b1;
    tick(); tick(); tick(); settle();
    check("br_t_exec", 32'({state_o, alu_control_o, alu_src_2_o, pc_write_o, pc_src_o, retired_o}),
          32'b011_10_0_111);
    branch_taken_i = 1'b0;
    settle();
    check("br_nt_exec", 32'({pc_write_o, pc_src_o, retired_o}), 32'b001);
    tick(); settle();
    check("br_next", 32'(state_o), 32'd1);
    check("br_instret", instret_o, 32'd3);

    // ---- Illegal opcode in DECODE ----
    opcode_i = C_OP_BAD;
    tick(); settle();
    check("ill_decode", 32'({state_o, illegal_o, retired_o}), 32'b010_11);
    tick(); settle();
    check("ill_next", 32'({state_o, illegal_o}), 32'b001_0);
    check("ill_instret", instret_o, 32'd4);

    // ---- Reset during a FETCH wait ----
    mem_ready_i = 1'b0; settle();
    check("rst_fetch_wait", 32'({state_o, mem_req_o}), 32'b001_1);
    rst_i = 1'b0;
    tick(); rst_i = 1'b1; start_i = 1'b0; settle();
    check("rst_mid_state", 32'({state_o, mem_req_o}), 32'd0);
    check("rst_mid_instret", instret_o, 32'd0);

    // ---- STORE with start_i dropped during the MEM wait ----
    start_i = 1'b1; mem_ready_i = 1'b1; opcode_i = C_OP_STORE;
    tick(); tick(); tick(); tick();
    start_i = 1'b0; mem_ready_i = 1'b0; settle();
    check("st_mem_wait", 32'({state_o, mem_req_o, mem_addr_sel_o, mem_we_o, retired_o}), 32'b100_111_0);
    tick(); settle();
    check("st_mem_wait2", 32'({state_o, mem_req_o, mem_we_o}), 32'b100_11);
    mem_ready_i = 1'b1; settle();
    check("st_mem_ready", 32'({mem_req_o, mem_addr_sel_o, mem_we_o, retired_o, reg_write_o}), 32'b11110);
    tick(); settle();
    check("st_idle", 32'(state_o), 32'd0);
    check("st_instret", instret_o, 32'd1);

    // ---- Counter wrap: preload all-ones, retire one illegal op ----
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    settle();
    check("wrap_preload", instret_o, 32'hFFFF_FFFF);
    start_i = 1'b1; opcode_i = C_OP_BAD;
    tick(); tick(); settle();
    check("wrap_decode", 32'({state_o, retired_o}), 32'b010_1);
    tick(); settle();
    check("wrap_instret", instret_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_multicycle_control
`default_nettype wire
